// File: rtl/partial_sum_acc_buffer_if.sv
// Bus bundle for partial_sum_acc_buffer: clear control, accumulate request and result output.
// The master side drives requests; the slave side is the buffer itself.
`timescale 1ns/1ps

interface partial_sum_acc_buffer_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned DW = 24,
  parameter int unsigned PW = 36,
  parameter int unsigned AW = 12
);

  // Sweep-clear control
  logic             clr_start;
  logic             clr_busy;
  logic             clr_done;

  // Accumulate request
  logic             acc_valid;
  logic             acc_ready;
  logic             acc_first;
  logic             acc_last;
  logic [AW-1:0]    acc_addr;
  logic [CH*DW-1:0] acc_data;

  // Result
  logic             out_valid;
  logic [AW-1:0]    out_addr;
  logic [CH*PW-1:0] out_data;
  logic             sat_flag;

  modport master (
    output clr_start,
    output acc_valid,
    output acc_first,
    output acc_last,
    output acc_addr,
    output acc_data,
    input  clr_busy,
    input  clr_done,
    input  acc_ready,
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  sat_flag
  );

  modport slave (
    input  clr_start,
    input  acc_valid,
    input  acc_first,
    input  acc_last,
    input  acc_addr,
    input  acc_data,
    output clr_busy,
    output clr_done,
    output acc_ready,
    output out_valid,
    output out_addr,
    output out_data,
    output sat_flag
  );

endinterface

// File: rtl/partial_sum_acc_buffer.sv
// Partial-sum accumulation buffer: CH banks of DEPTH x PW words, in-place read-modify-write
// accumulation of PE partial sums with one-deep read-after-write forwarding and a hardware
// sweep-clear FSM.
// Optional feature macro: PSUM_SAT_EN (saturating per-lane sums plus sticky sat_flag).
// Without it sums wrap modulo 2^PW and sat_flag is tied low.
`timescale 1ns/1ps

module partial_sum_acc_buffer #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DW    = 24,
  parameter int unsigned PW    = 36,
  parameter int unsigned DEPTH = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  partial_sum_acc_buffer_if.slave       bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StClear
  } clr_state_e;

  clr_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy;
  logic          clr_we;
  logic          clr_done;
  logic          acc_fire;

  // S1 stage
  logic             s1_valid_q;
  logic [AW-1:0]    s1_addr_q;
  logic             s1_first_q;
  logic             s1_last_q;
  logic [CH*DW-1:0] s1_data_q;
  logic [CH*PW-1:0] s1_sum;

  // Forwarding: previous S1 sum replaces stale read data on a same-address follow-up
  logic             fwd_q;
  logic [CH*PW-1:0] fwd_sum_q;

  // Memory ports
  logic [CH*PW-1:0] rd_data;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [CH*PW-1:0] mem_wdata;

  // Result
  logic             out_valid_q;
  logic [AW-1:0]    out_addr_q;
  logic [CH*PW-1:0] out_data_q;

`ifdef PSUM_SAT_EN
  logic sat_hit;
  logic sat_q;
  logic clr_accept;
`endif

  assign busy     = (state_q != StIdle);
  assign acc_fire = bus.acc_valid & ~busy;

  assign bus.clr_busy  = busy;
  assign bus.clr_done  = clr_done;
  assign bus.acc_ready = ~busy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;

  // Clear FSM state and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM next-state: DRAIN gives an in-flight S1 write one cycle to land before sweeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we   = 1'b0;
    clr_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_start) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StClear;
        cnt_d   = '0;
      end
      StClear: begin
        clr_we = 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d  = StIdle;
          clr_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // S1 control and forwarding flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
    end else begin
      s1_valid_q <= acc_fire;
      fwd_q      <= acc_fire & s1_valid_q & (bus.acc_addr == s1_addr_q);
    end
  end

  // S1 payload capture; the current S1 sum is kept as the forwarding operand
  always_ff @(posedge clk) begin
    if (acc_fire) begin
      s1_addr_q  <= bus.acc_addr;
      s1_first_q <= bus.acc_first;
      s1_last_q  <= bus.acc_last;
      s1_data_q  <= bus.acc_data;
      fwd_sum_q  <= s1_sum;
    end
  end

  // Per-lane accumulate: operand select, sign-extend and add (optionally clamp)
  always_comb begin : sum_comb
    logic signed [PW-1:0] base;
    logic signed [DW-1:0] addend;
`ifdef PSUM_SAT_EN
    logic signed [PW:0]   wide;
    wide    = '0;
    sat_hit = 1'b0;
`endif
    base   = '0;
    addend = '0;
    s1_sum = '0;
    for (int i = 0; i < int'(CH); i++) begin
      if (s1_first_q) begin
        base = '0;
      end else if (fwd_q) begin
        base = fwd_sum_q[i*PW +: PW];
      end else begin
        base = rd_data[i*PW +: PW];
      end
      addend = s1_data_q[i*DW +: DW];
`ifdef PSUM_SAT_EN
      // One extra bit holds the exact sum; differing top bits mean the PW result overflowed
      wide = base + addend;
      if (wide[PW] != wide[PW-1]) begin
        sat_hit = 1'b1;
        s1_sum[i*PW +: PW] = wide[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
      end else begin
        s1_sum[i*PW +: PW] = wide[PW-1:0];
      end
`else
      s1_sum[i*PW +: PW] = base + addend;
`endif
    end
  end

  // Write port shared between S1 write-back and the clear sweep (never both active)
  always_comb begin
    mem_we    = s1_valid_q | clr_we;
    mem_waddr = clr_we ? cnt_q : s1_addr_q;
    mem_wdata = clr_we ? '0 : s1_sum;
  end

  for (genvar b = 0; b < int'(CH); b++) begin : g_bank
    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_q;

    // Bank write port
    always_ff @(posedge clk) begin
      if (mem_we) begin
        mem[mem_waddr] <= mem_wdata[b*PW +: PW];
      end
    end

    // Bank synchronous read port, issued on request acceptance
    always_ff @(posedge clk) begin
      if (acc_fire) begin
        rd_q <= mem[bus.acc_addr];
      end
    end

    assign rd_data[b*PW +: PW] = rd_q;
  end

  // Result register: presents the written value of last-pass requests for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= s1_valid_q & s1_last_q;
      if (s1_valid_q & s1_last_q) begin
        out_addr_q <= s1_addr_q;
        out_data_q <= s1_sum;
      end
    end
  end

`ifdef PSUM_SAT_EN
  assign clr_accept = (state_q == StIdle) & bus.clr_start;

  // Sticky saturation flag; a clamp from a request already in S1 survives a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= (sat_q & ~clr_accept) | (s1_valid_q & sat_hit);
    end
  end

  assign bus.sat_flag = sat_q;
`else
  assign bus.sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_partial_sum_acc_buffer.sv
// Self-checking bench for partial_sum_acc_buffer: directed clear/accumulate sequences plus a
// randomized accumulate stream checked against an array-based reference model.
`timescale 1ns/1ps

module tb_partial_sum_acc_buffer;

  localparam int unsigned CH     = 4;
  localparam int unsigned DW     = 24;
  localparam int unsigned PW     = 36;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned AW     = 7;
  localparam int unsigned SDEPTH = 16;
  localparam int unsigned SAW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  partial_sum_acc_buffer_if #(.CH(CH), .DW(DW), .PW(PW), .AW(AW)) m_if ();
  partial_sum_acc_buffer_if #(.CH(1), .DW(8), .PW(8), .AW(SAW)) s_if ();

  partial_sum_acc_buffer #(.CH(CH), .DW(DW), .PW(PW), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  partial_sum_acc_buffer #(.CH(1), .DW(8), .PW(8), .DEPTH(SDEPTH)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int               due;
    logic [AW-1:0]    addr;
    logic [CH*PW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic signed [PW-1:0] model_mem [CH][DEPTH];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < int'(CH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        model_mem[i][j] = '0;
      end
    end
  endtask

  // Reference: accepted request updates the word immediately; last passes are due 2 cycles later
  task automatic model_accept();
    exp_t                 e;
    logic signed [DW-1:0] d;
    logic signed [PW-1:0] base;
    e.due  = cyc + 2;
    e.addr = m_if.acc_addr;
    e.data = '0;
    for (int i = 0; i < int'(CH); i++) begin
      d    = m_if.acc_data[i*DW +: DW];
      base = m_if.acc_first ? '0 : model_mem[i][m_if.acc_addr];
      model_mem[i][m_if.acc_addr] = base + d;
      e.data[i*PW +: PW] = model_mem[i][m_if.acc_addr];
    end
    if (m_if.acc_last) exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check("out_valid", 256'(m_if.out_valid), 256'(1));
        check("out_addr", 256'(m_if.out_addr), 256'(exp_q[0].addr));
        check("out_data", 256'(m_if.out_data), 256'(exp_q[0].data));
        void'(exp_q.pop_front());
      end else begin
        check("out_idle", 256'(m_if.out_valid), 256'(0));
      end
      if (m_if.acc_valid && m_if.acc_ready) model_accept();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH*DW-1:0] lanes(input int v);
    logic [CH*DW-1:0] r;
    for (int i = 0; i < int'(CH); i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [CH*DW-1:0] rand_data();
    logic [CH*DW-1:0] r;
    for (int i = 0; i < int'(CH); i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Present a request and hold it until accepted (bounded); valid stays high afterwards
  task automatic acc(input logic [AW-1:0] a, input logic f, input logic l,
                     input logic [CH*DW-1:0] d);
    int n;
    m_if.acc_valid = 1'b1;
    m_if.acc_addr  = a;
    m_if.acc_first = f;
    m_if.acc_last  = l;
    m_if.acc_data  = d;
    n = 0;
    while (!m_if.acc_ready && n < int'(4 * DEPTH)) begin
      tick();
      n++;
    end
    check("acc_accept", 256'(m_if.acc_ready), 256'(1));
    tick();
  endtask

  task automatic idle(input int n);
    m_if.acc_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n;
    m_if.acc_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic do_clear();
    int busy_n, done_n, done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    m_if.clr_start = 1'b1;
    tick();
    m_if.clr_start = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 8; i++) begin
      if (m_if.clr_busy) busy_n++;
      if (m_if.clr_done) begin
        done_n++;
        done_at = i;
      end
      tick();
    end
    check("clr_busy_cycles", 256'(busy_n), 256'(DEPTH + 1));
    check("clr_done_count", 256'(done_n), 256'(1));
    check("clr_done_at", 256'(done_at), 256'(DEPTH));
    model_zero();
  endtask

  logic [7:0] s_exp_out;
  logic       s_exp_sat;

  initial begin
    int  n;
    int  done_n;
    logic seen;
    logic [CH*DW-1:0] d4;

    m_if.clr_start = 1'b0;
    m_if.acc_valid = 1'b0;
    m_if.acc_first = 1'b0;
    m_if.acc_last  = 1'b0;
    m_if.acc_addr  = '0;
    m_if.acc_data  = '0;
    s_if.clr_start = 1'b0;
    s_if.acc_valid = 1'b0;
    s_if.acc_first = 1'b0;
    s_if.acc_last  = 1'b0;
    s_if.acc_addr  = '0;
    s_if.acc_data  = '0;
    model_zero();

    // Reset state
    repeat (3) tick();
    check("rst_clr_busy", 256'(m_if.clr_busy), 256'(0));
    check("rst_clr_done", 256'(m_if.clr_done), 256'(0));
    check("rst_out_valid", 256'(m_if.out_valid), 256'(0));
    check("rst_out_addr", 256'(m_if.out_addr), 256'(0));
    check("rst_out_data", 256'(m_if.out_data), 256'(0));
    check("rst_sat_flag", 256'(m_if.sat_flag), 256'(0));
    rst = 1'b0;
    tick();
    check("rst_acc_ready", 256'(m_if.acc_ready), 256'(1));

    // Sweep clear and read back zeros, including the top address
    do_clear();
    acc(AW'(3), 1'b0, 1'b1, lanes(0));
    acc(AW'(DEPTH - 1), 1'b0, 1'b1, lanes(0));
    acc(AW'(0), 1'b0, 1'b1, lanes(0));
    drain();

    // Spaced accumulation at one address
    acc(AW'(5), 1'b1, 1'b0, lanes(10));
    idle(3);
    acc(AW'(5), 1'b0, 1'b0, lanes(-3));
    idle(3);
    acc(AW'(5), 1'b0, 1'b1, lanes(7));
    drain();

    // Back-to-back same address exercises forwarding
    acc(AW'(9), 1'b1, 1'b0, lanes(1));
    acc(AW'(9), 1'b0, 1'b0, lanes(2));
    acc(AW'(9), 1'b0, 1'b0, lanes(3));
    acc(AW'(9), 1'b0, 1'b1, lanes(4));
    drain();

    // Randomized stream over a small address window
    for (int k = 0; k < 300; k++) begin
      acc(AW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          rand_data());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    drain();

    // Saturation boundary on the narrow instance
`ifdef PSUM_SAT_EN
    s_exp_out = 8'h7f;
    s_exp_sat = 1'b1;
`else
    s_exp_out = 8'h80;
    s_exp_sat = 1'b0;
`endif
    s_if.acc_valid = 1'b1;
    s_if.acc_addr  = SAW'(2);
    s_if.acc_first = 1'b1;
    s_if.acc_last  = 1'b0;
    s_if.acc_data  = 8'd127;
    tick();
    s_if.acc_valid = 1'b0;
    repeat (3) tick();
    s_if.acc_valid = 1'b1;
    s_if.acc_first = 1'b0;
    s_if.acc_last  = 1'b1;
    s_if.acc_data  = 8'd1;
    tick();
    s_if.acc_valid = 1'b0;
    tick();
    check("sat_out_valid", 256'(s_if.out_valid), 256'(1));
    check("sat_out_addr", 256'(s_if.out_addr), 256'(2));
    check("sat_out_data", 256'(s_if.out_data), 256'(s_exp_out));
    check("sat_flag", 256'(s_if.sat_flag), 256'(s_exp_sat));
    tick();
    check("sat_out_idle", 256'(s_if.out_valid), 256'(0));
    check("sat_flag_sticky", 256'(s_if.sat_flag), 256'(s_exp_sat));
    s_if.clr_start = 1'b1;
    tick();
    s_if.clr_start = 1'b0;
    check("sat_flag_cleared", 256'(s_if.sat_flag), 256'(0));

    // Request held during a clear: accepted alongside clr_start, then stalled until the sweep ends
    d4 = rand_data();
    m_if.clr_start = 1'b1;
    m_if.acc_valid = 1'b1;
    m_if.acc_addr  = AW'(20);
    m_if.acc_first = 1'b0;
    m_if.acc_last  = 1'b1;
    m_if.acc_data  = d4;
    tick();
    m_if.clr_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 8; i++) begin
      check("ready_while_busy", 256'(m_if.acc_ready), 256'(0));
      if (m_if.clr_done) begin
        seen = 1'b1;
        model_zero();
        tick();
        break;
      end
      tick();
    end
    check("clr_done_seen", 256'(seen), 256'(1));
    check("ready_after_done", 256'(m_if.acc_ready), 256'(1));
    tick();
    drain();

    // Reset in the middle of a sweep aborts it
    done_n = 0;
    m_if.clr_start = 1'b1;
    tick();
    m_if.clr_start = 1'b0;
    for (int i = 0; i < 101; i++) begin
      if (m_if.clr_done) done_n++;
      tick();
    end
    check("mid_clear_busy", 256'(m_if.clr_busy), 256'(1));
    rst = 1'b1;
    tick();
    check("abort_busy", 256'(m_if.clr_busy), 256'(0));
    check("abort_done", 256'(m_if.clr_done), 256'(0));
    rst = 1'b0;
    check("abort_ready", 256'(m_if.acc_ready), 256'(1));
    n = 0;
    repeat (5) begin
      if (m_if.clr_done) n++;
      tick();
    end
    check("abort_no_done", 256'(done_n + n), 256'(0));

    // Full clear again, then a short mixed stream
    do_clear();
    for (int k = 0; k < 40; k++) begin
      acc(AW'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 1'b1, rand_data());
    end
    drain();
    check("main_sat_flag", 256'(m_if.sat_flag), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
